// File: rtl/json_stream_arbiter.sv
// Round-robin, per-document arbiter feeding one JSON tokenizer byte port.
// Tracks nesting depth and string state in flight and pulses framing errors.
module json_stream_arbiter #(
    parameter int N_REQ   = 4,
    parameter int DEPTH_W = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [N_REQ-1:0]           in_valid,
    output logic [N_REQ-1:0]           in_ready,
    input  logic [8*N_REQ-1:0]         in_data,
    input  logic [N_REQ-1:0]           in_last,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [7:0]                 out_data,
    output logic                       out_last,
    output logic [$clog2(N_REQ)-1:0]   out_src,
    output logic [DEPTH_W-1:0]         out_depth,
    output logic                       err,
    output logic [1:0]                 err_code
);

    localparam int SRC_W = $clog2(N_REQ);
    localparam logic [DEPTH_W-1:0] MAX_D = '1;

    localparam logic [7:0] CH_LBRACE = 8'h7b;
    localparam logic [7:0] CH_RBRACE = 8'h7d;
    localparam logic [7:0] CH_LBRACK = 8'h5b;
    localparam logic [7:0] CH_RBRACK = 8'h5d;
    localparam logic [7:0] CH_QUOTE  = 8'h22;
    localparam logic [7:0] CH_BSLASH = 8'h5c;

    typedef enum logic {IDLE, BUSY} state_t;

    state_t             state_q, state_d;
    logic [SRC_W-1:0]   rr_ptr_q, rr_ptr_d;
    logic [SRC_W-1:0]   gnt_q, gnt_d;
    logic [DEPTH_W-1:0] depth_q, depth_d;
    logic               in_str_q, in_str_d;
    logic               esc_q, esc_d;
    logic               err_q, err_d;
    logic [1:0]         err_code_q, err_code_d;

    logic [SRC_W-1:0]   pick;
    logic               found;
    int                 idx;
    logic [7:0]         cur_byte;
    logic               hs;

    // First requesting index at or after rr_ptr, wrapping.
    always_comb begin
        pick  = '0;
        found = 1'b0;
        idx   = 0;
        for (int k = 0; k < N_REQ; k++) begin
            idx = (int'(rr_ptr_q) + k) % N_REQ;
            if (!found && in_valid[idx]) begin
                found = 1'b1;
                pick  = SRC_W'(idx);
            end
        end
    end

    assign cur_byte = in_data[int'(gnt_q)*8 +: 8];

    always_comb begin
        state_d    = state_q;
        rr_ptr_d   = rr_ptr_q;
        gnt_d      = gnt_q;
        depth_d    = depth_q;
        in_str_d   = in_str_q;
        esc_d      = esc_q;
        err_d      = 1'b0;
        err_code_d = 2'd0;
        in_ready   = '0;
        out_valid  = 1'b0;
        out_data   = 8'h00;
        out_last   = 1'b0;
        hs         = 1'b0;

        unique case (state_q)
            IDLE: begin
                depth_d  = '0;
                in_str_d = 1'b0;
                esc_d    = 1'b0;
                if (found) begin
                    gnt_d   = pick;
                    state_d = BUSY;
                end
            end
            BUSY: begin
                out_valid       = in_valid[gnt_q];
                out_data        = cur_byte;
                out_last        = in_last[gnt_q];
                in_ready[gnt_q] = out_ready;
                hs              = out_valid && out_ready;
                if (hs) begin
                    if (esc_q) begin
                        esc_d = 1'b0;
                    end else if (in_str_q) begin
                        if (cur_byte == CH_BSLASH) begin
                            esc_d = 1'b1;
                        end else if (cur_byte == CH_QUOTE) begin
                            in_str_d = 1'b0;
                        end
                    end else if (cur_byte == CH_QUOTE) begin
                        in_str_d = 1'b1;
                    end else if (cur_byte == CH_LBRACE || cur_byte == CH_LBRACK) begin
                        if (depth_q == MAX_D) begin
                            err_d      = 1'b1;
                            err_code_d = 2'd2;
                        end else begin
                            depth_d = depth_q + 1'b1;
                        end
                    end else if (cur_byte == CH_RBRACE || cur_byte == CH_RBRACK) begin
                        if (depth_q == '0) begin
                            err_d      = 1'b1;
                            err_code_d = 2'd3;
                        end else begin
                            depth_d = depth_q - 1'b1;
                        end
                    end
                    // Balance is judged on the state after the last byte.
                    if (out_last) begin
                        if (depth_d != '0 || in_str_d) begin
                            err_d      = 1'b1;
                            err_code_d = 2'd1;
                        end
                        state_d  = IDLE;
                        rr_ptr_d = (gnt_q == SRC_W'(N_REQ - 1)) ? '0 : gnt_q + 1'b1;
                    end
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            rr_ptr_q   <= '0;
            gnt_q      <= '0;
            depth_q    <= '0;
            in_str_q   <= 1'b0;
            esc_q      <= 1'b0;
            err_q      <= 1'b0;
            err_code_q <= 2'd0;
        end else begin
            state_q    <= state_d;
            rr_ptr_q   <= rr_ptr_d;
            gnt_q      <= gnt_d;
            depth_q    <= depth_d;
            in_str_q   <= in_str_d;
            esc_q      <= esc_d;
            err_q      <= err_d;
            err_code_q <= err_code_d;
        end
    end

    assign out_src   = gnt_q;
    assign out_depth = depth_q;
    assign err       = err_q;
    assign err_code  = err_code_q;

endmodule

// File: tb/tb_json_stream_arbiter.sv
// Directed bench for json_stream_arbiter with a per-source byte scoreboard.
// Depth and error expectations are written as constant per-byte tables.
module tb_json_stream_arbiter;

    localparam int N = 4;
    localparam int DW = 4;

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic [N-1:0]   in_valid = '0;
    logic [N-1:0]   in_ready;
    logic [8*N-1:0] in_data = '0;
    logic [N-1:0]   in_last = '0;
    logic           out_valid;
    logic           out_ready = 1'b1;
    logic [7:0]     out_data;
    logic           out_last;
    logic [1:0]     out_src;
    logic [DW-1:0]  out_depth;
    logic           err;
    logic [1:0]     err_code;

    json_stream_arbiter #(.N_REQ(N), .DEPTH_W(DW)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_data(in_data), .in_last(in_last),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .out_last(out_last),
        .out_src(out_src), .out_depth(out_depth),
        .err(err), .err_code(err_code)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] d;
        logic       l;
        logic [3:0] dep;
        logic [1:0] ec;
    } exp_t;

    exp_t exp_q [N][$];
    int   gnt_exp [$];
    int   n_cmp = 0;
    int   n_err = 0;
    int   cyc = 0;
    int   first_hs = 0;
    int   last_hs = 0;
    int   gap = 0;
    bit   bp = 1'b0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [3:0] hexv(input byte c);
        return (c >= 8'h61) ? 4'(c - 8'h57) : 4'(c - 8'h30);
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_doc(input int r, input string s, input string dep,
                            input string ec, input bit last_en);
        exp_t e;
        bit   hs;
        int   n;
        for (int i = 0; i < s.len(); i++) begin
            in_valid[r]       = 1'b1;
            in_data[r*8 +: 8] = s[i];
            in_last[r]        = last_en && (i == s.len() - 1);
            e.d   = s[i];
            e.l   = in_last[r];
            e.dep = hexv(dep[i]);
            e.ec  = 2'(ec[i] - 8'h30);
            exp_q[r].push_back(e);
            hs = 1'b0;
            n  = 0;
            while (!hs) begin
                @(negedge clk);
                hs = in_ready[r];
                tick();
                n++;
                if (!hs && n > 200) begin
                    n_cmp++;
                    n_err++;
                    $error("FAIL timeout req=%0d byte=%0d observed=stalled expected=accepted", r, i);
                    hs = 1'b1;
                end
            end
        end
        in_valid[r] = 1'b0;
        in_last[r]  = 1'b0;
    endtask

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    initial forever begin
        @(posedge clk);
        #1;
        out_ready = bp ? ~out_ready : 1'b1;
    end

    // Output monitor: pops the scoreboard on every handshake.
    initial begin : monitor
        int   pend;
        int   cur;
        bit   doc_start;
        bit   first_pending;
        exp_t e;
        pend = 0;
        cur = 0;
        doc_start = 1'b1;
        first_pending = 1'b1;
        forever begin
            @(negedge clk);
            if (rst) begin
                pend = 0;
                doc_start = 1'b1;
                first_pending = 1'b1;
            end else begin
                chk("err", err, pend != 0);
                if (pend != 0) chk("err_code", err_code, pend);
                pend = 0;
                if (out_valid) begin
                    if (doc_start) begin
                        doc_start = 1'b0;
                        if (gnt_exp.size() == 0) begin
                            n_cmp++;
                            n_err++;
                            $error("FAIL grant observed=%0d expected=none", out_src);
                        end else begin
                            cur = gnt_exp.pop_front();
                            chk("grant_src", out_src, cur);
                        end
                    end
                    chk("in_ready", in_ready, out_ready ? (32'd1 << cur) : 32'd0);
                    if (out_ready) begin
                        if (first_pending) begin
                            gap = cyc - last_hs;
                            first_hs = cyc;
                            first_pending = 1'b0;
                        end
                        if (exp_q[cur].size() == 0) begin
                            n_cmp++;
                            n_err++;
                            $error("FAIL byte observed=%0h expected=none", out_data);
                        end else begin
                            e = exp_q[cur].pop_front();
                            chk("out_data", out_data, e.d);
                            chk("out_last", out_last, e.l);
                            chk("out_depth", out_depth, e.dep);
                            chk("out_src", out_src, cur);
                            pend = e.ec;
                            if (e.l) begin
                                doc_start = 1'b1;
                                first_pending = 1'b1;
                                last_hs = cyc;
                            end
                        end
                    end
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog observed=running expected=finished");
        $fatal(1, "watchdog");
    end

    initial begin : stim
        int t0;
        repeat (3) tick();
        @(negedge clk);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_in_ready", in_ready, 0);
        chk("rst_out_data", out_data, 0);
        chk("rst_out_last", out_last, 0);
        chk("rst_out_src", out_src, 0);
        chk("rst_out_depth", out_depth, 0);
        chk("rst_err", err, 0);
        chk("rst_err_code", err_code, 0);
        tick();
        rst = 1'b0;
        repeat (2) tick();

        // Single document, latency and burst length
        t0 = cyc;
        gnt_exp.push_back(2);
        send_doc(2, "{\"a\":[1]}", "011111221", "000000000", 1'b1);
        chk("arb_latency", first_hs - t0, 1);
        chk("burst_len", last_hs - first_hs, 8);
        repeat (2) tick();

        // Contention: 0, then 1, then 0 again
        gnt_exp.push_back(0);
        gnt_exp.push_back(1);
        gnt_exp.push_back(0);
        fork
            begin
                send_doc(0, "[1]", "011", "000", 1'b1);
                send_doc(0, "[1]", "011", "000", 1'b1);
            end
            send_doc(1, "[1]", "011", "000", 1'b1);
        join
        repeat (2) tick();

        // Strings and escapes
        gnt_exp.push_back(3);
        send_doc(3, "{\"x\\\"]\":0}", "0111111111", "0000000000", 1'b1);
        repeat (2) tick();

        // Errors; second doc back-to-back from the same requester
        gnt_exp.push_back(0);
        gnt_exp.push_back(0);
        send_doc(0, "[[", "01", "01", 1'b1);
        send_doc(0, "]", "0", "3", 1'b1);
        chk("b2b_gap", gap, 2);
        repeat (2) tick();
        gnt_exp.push_back(1);
        send_doc(1, "[[[[[[[[[[[[[[[[]", "0123456789abcdeff",
                 "00000000000000021", 1'b1);
        repeat (2) tick();

        // Backpressure
        bp = 1'b1;
        gnt_exp.push_back(2);
        send_doc(2, "[{}]", "0121", "0000", 1'b1);
        bp = 1'b0;
        repeat (3) tick();

        // Reset mid-document
        gnt_exp.push_back(1);
        send_doc(1, "{\"a", "011", "000", 1'b0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        @(negedge clk);
        chk("post_rst_valid", out_valid, 0);
        chk("post_rst_depth", out_depth, 0);
        tick();
        gnt_exp.push_back(0);
        send_doc(0, "[1]", "011", "000", 1'b1);
        repeat (5) tick();

        for (int r = 0; r < N; r++) chk("sb_empty", exp_q[r].size(), 0);
        chk("gnt_empty", gnt_exp.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
